// File: rtl/uart_cmd_parser.sv
// UART command-frame decoder: [A5][CMD][ADDR][DATA][CHK] -> register strobe + one response byte.
// Optional inter-byte timeout is compiled in with `define UART_CMD_TIMEOUT_EN.
module uart_cmd_parser #(
  parameter int                   DATA_BITS      = 8,
  parameter int                   ADDR_BITS      = 8,
  parameter logic [DATA_BITS-1:0] HEADER         = 8'hA5,
  parameter int                   TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_done_tick,
  input  logic [DATA_BITS-1:0] i_rx_data,
  output logic                 o_tx_start,
  output logic [DATA_BITS-1:0] o_tx_data,
  input  logic                 i_tx_done_tick,
  output logic                 o_wr_en,
  output logic                 o_rd_en,
  output logic [ADDR_BITS-1:0] o_addr,
  output logic [DATA_BITS-1:0] o_wr_data,
  input  logic [DATA_BITS-1:0] i_rd_data,
  output logic                 o_busy,
  output logic                 o_err_tick
);

  localparam logic [DATA_BITS-1:0] CMD_WR = DATA_BITS'(8'h01);
  localparam logic [DATA_BITS-1:0] CMD_RD = DATA_BITS'(8'h02);
  localparam logic [DATA_BITS-1:0] ACK    = DATA_BITS'(8'h06);
  localparam logic [DATA_BITS-1:0] NAK    = DATA_BITS'(8'h15);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_CHK, S_EXEC, S_RESP, S_WAIT_TX
  } state_t;

  state_t               r_state, w_state_next;
  logic [DATA_BITS-1:0] r_cmd, r_addr_byte, r_data, r_wr_data, r_tx_data;
  logic [ADDR_BITS-1:0] r_addr_out;
  logic                 r_chk_ok;
  logic                 w_cmd_wr, w_cmd_rd, w_timeout;

  // Frame contents stay frozen through EXEC/RESP because late bytes are dropped.
  assign w_cmd_wr = r_chk_ok && (r_cmd == CMD_WR);
  assign w_cmd_rd = r_chk_ok && (r_cmd == CMD_RD);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            w_in_get;

  assign w_in_get  = (r_state == S_GET_CMD) || (r_state == S_GET_ADDR) ||
                     (r_state == S_GET_DATA) || (r_state == S_GET_CHK);
  assign w_timeout = w_in_get && !i_rx_done_tick && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || !w_in_get || i_rx_done_tick) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_wr_en      = 1'b0;
    o_rd_en      = 1'b0;
    o_tx_start   = 1'b0;
    o_err_tick   = 1'b0;
    case (r_state)
      S_IDLE:     if (i_rx_done_tick && (i_rx_data == HEADER)) w_state_next = S_GET_CMD;
      S_GET_CMD:  if (i_rx_done_tick) w_state_next = S_GET_ADDR;
      S_GET_ADDR: if (i_rx_done_tick) w_state_next = S_GET_DATA;
      S_GET_DATA: if (i_rx_done_tick) w_state_next = S_GET_CHK;
      S_GET_CHK:  if (i_rx_done_tick) w_state_next = S_EXEC;
      S_EXEC: begin
        o_wr_en      = w_cmd_wr;
        o_rd_en      = w_cmd_rd;
        o_err_tick   = !(w_cmd_wr || w_cmd_rd);
        w_state_next = S_RESP;
      end
      S_RESP: begin
        o_tx_start   = 1'b1;
        w_state_next = S_WAIT_TX;
      end
      S_WAIT_TX:  if (i_tx_done_tick) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_next = S_IDLE;
      o_err_tick   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd       <= '0;
      r_addr_byte <= '0;
      r_data      <= '0;
      r_chk_ok    <= 1'b0;
      r_addr_out  <= '0;
      r_wr_data   <= '0;
      r_tx_data   <= '0;
    end else begin
      if (i_rx_done_tick) begin
        case (r_state)
          S_GET_CMD:  r_cmd       <= i_rx_data;
          S_GET_ADDR: r_addr_byte <= i_rx_data;
          S_GET_DATA: r_data      <= i_rx_data;
          S_GET_CHK: begin
            r_chk_ok   <= (i_rx_data == (r_cmd ^ r_addr_byte ^ r_data));
            r_addr_out <= r_addr_byte[ADDR_BITS-1:0];
            r_wr_data  <= r_data;
          end
          default: ;
        endcase
      end
      // Reads take their byte from i_rd_data in RESP; it is captured here for WAIT_TX.
      if ((r_state == S_EXEC) && !w_cmd_rd) r_tx_data <= w_cmd_wr ? ACK : NAK;
      if ((r_state == S_RESP) && w_cmd_rd)  r_tx_data <= i_rd_data;
    end
  end

  assign o_tx_data = ((r_state == S_RESP) && w_cmd_rd) ? i_rd_data : r_tx_data;
  assign o_addr    = r_addr_out;
  assign o_wr_data = r_wr_data;
  assign o_busy    = (r_state != S_IDLE);

endmodule
